// File: rtl/sr_latch_driver.sv
// sr_latch_driver: debounces two raw buttons into exclusive, fixed-width
// active-low set/reset pulses for a cross-coupled NAND SR latch.
module sr_latch_driver #(
  parameter int DB_CYCLES = 16,
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 1
) (
  input  logic clk,
  input  logic rstbar,
  input  logic set_btn,
  input  logic rst_btn,
  output logic sbar,
  output logic rbar,
  output logic busy
);
  localparam int CW   = $clog2(DB_CYCLES);
  localparam int TMAX = PULSE_W > GAP_W ? PULSE_W : GAP_W;
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
  typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_t;
  state_t state, state_n;
  logic [1:0] cap, sync1, sync2, db, db_q, pend, press, clr;
  logic [CW-1:0] cnt [2];
  logic [TW-1:0] tcnt, tcnt_n;
  // bit 0 is the set channel, bit 1 the reset channel
  assign press = db & ~db_q;
  always_comb begin
    state_n = state;
    tcnt_n = tcnt + TW'(1);
    clr = '0;
    unique case (state)
      IDLE: begin
        tcnt_n = '0;
        state_n = pend[1] ? RST_P : pend[0] ? SET_P : IDLE;
        clr = pend[1] ? 2'b10 : {1'b0, pend[0]};
      end
      SET_P, RST_P: if (tcnt == TW'(PULSE_W - 1)) begin
        state_n = GAP;
        tcnt_n = '0;
      end
      GAP: if (tcnt == TW'(GAP_W - 1)) begin
        state_n = IDLE;
        tcnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // a press event on the same edge as its clear keeps the request pending
  always_ff @(posedge clk or negedge rstbar)
    if (!rstbar) begin
      cap <= '0;
      sync1 <= '0;
      sync2 <= '0;
      db <= '0;
      db_q <= '0;
      cnt <= '{default: '0};
      pend <= '0;
      state <= IDLE;
      tcnt <= '0;
      sbar <= 1'b1;
      rbar <= 1'b1;
      busy <= 1'b0;
    end else begin
      cap <= {rst_btn, set_btn};
      sync1 <= cap;
      sync2 <= sync1;
      db_q <= db;
      pend <= (pend & ~clr) | press;
      state <= state_n;
      tcnt <= tcnt_n;
      sbar <= state_n != SET_P;
      rbar <= state_n != RST_P;
      busy <= state_n != IDLE;
      for (int i = 0; i < 2; i++)
        if (sync2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          db[i] <= sync2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
    end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed checks of debounce, pulse timing, arbitration and reset.
module tb_sr_latch_driver;
  logic clk = 1'b0, rstbar = 1'b0;
  logic set_btn = 1'b0, rst_btn = 1'b0, set2 = 1'b0, rst2 = 1'b0;
  logic sbar, rbar, busy, sbar2, rbar2, busy2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sr_latch_driver #(.DB_CYCLES(4), .PULSE_W(2), .GAP_W(1)) dut (
    .clk(clk), .rstbar(rstbar), .set_btn(set_btn), .rst_btn(rst_btn),
    .sbar(sbar), .rbar(rbar), .busy(busy));
  // long pulses keep the FSM busy long enough for a second set press to merge
  sr_latch_driver #(.DB_CYCLES(4), .PULSE_W(12), .GAP_W(1)) dut2 (
    .clk(clk), .rstbar(rstbar), .set_btn(set2), .rst_btn(rst2),
    .sbar(sbar2), .rbar(rbar2), .busy(busy2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  // edge i: ls/lr = sbar/rbar expected low, b = busy expected
  task automatic cyc(input int i, input bit ls, input bit lr, input bit b);
    @(posedge clk);
    #1;
    chk($sformatf("sbar@%0d", i), sbar, !ls);
    chk($sformatf("rbar@%0d", i), rbar, !lr);
    chk($sformatf("busy@%0d", i), busy, b);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(i, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    chk("excl", {31'd0, ~sbar & ~rbar}, 0);
    chk("excl2", {31'd0, ~sbar2 & ~rbar2}, 0);
  end
  initial begin
    logic [15:0] pat;
    int lows, falls, first;
    logic prev;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sbar", sbar, 1);
    chk("rst_rbar", rbar, 1);
    chk("rst_busy", busy, 0);
    rstbar = 1'b1;
    idle(4);
    set_btn = 1'b1;
    for (int i = 0; i < 20; i++) cyc(i, i inside {[8:9]}, 0, i inside {[8:10]});
    set_btn = 1'b0;
    idle(12);
    pat = 16'b0000_0000_1110_0111;
    set_btn = pat[0];
    for (int i = 0; i < 20; i++) begin
      cyc(i, 0, 0, 0);
      set_btn = i < 15 ? pat[i+1] : 1'b0;
    end
    idle(8);
    pat = 16'b1111_1111_1110_0111;
    set_btn = pat[0];
    for (int i = 0; i < 25; i++) begin
      cyc(i, i inside {[13:14]}, 0, i inside {[13:15]});
      set_btn = i < 15 ? pat[i+1] : 1'b1;
    end
    set_btn = 1'b0;
    idle(12);
    set_btn = 1'b1;
    rst_btn = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc(i, i inside {[12:13]}, i inside {[8:9]}, i inside {[8:10], [12:14]});
    set_btn = 1'b0;
    rst_btn = 1'b0;
    idle(12);
    set_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(i, i inside {[8:9]}, i inside {[12:13]}, i inside {[8:10], [12:14]});
      if (i == 2) rst_btn = 1'b1;
    end
    set_btn = 1'b0;
    rst_btn = 1'b0;
    idle(12);
    set2 = 1'b1;
    rst2 = 1'b1;
    lows = 0;
    falls = 0;
    first = -1;
    prev = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (!sbar2) begin
        lows++;
        if (prev) falls++;
        if (first < 0) first = i;
      end
      prev = sbar2;
      if (i == 3) set2 = 1'b0;
      if (i == 7) set2 = 1'b1;
    end
    chk("merge_lows", lows, 12);
    chk("merge_falls", falls, 1);
    chk("merge_start", first, 22);
    chk("merge_busy2", busy2, 0);
    set2 = 1'b0;
    rst2 = 1'b0;
    idle(12);
    set_btn = 1'b1;
    for (int i = 0; i < 100; i++) cyc(i, i inside {[8:9]}, 0, i inside {[8:10]});
    set_btn = 1'b0;
    idle(15);
    set_btn = 1'b1;
    for (int i = 0; i < 9; i++) cyc(i, i == 8, 0, i == 8);
    #2 rstbar = 1'b0;
    #1;
    chk("async_sbar", sbar, 1);
    chk("async_rbar", rbar, 1);
    chk("async_busy", busy, 0);
    set_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstbar = 1'b1;
    idle(15);
    rstbar = 1'b0;
    set_btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstbar = 1'b1;
    for (int i = 0; i < 16; i++) cyc(i, i inside {[8:9]}, 0, i inside {[8:10]});
    set_btn = 1'b0;
    idle(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
